// File: rtl/cond_pkg.sv
// Shared condition-code constants, flag bit positions and the stage-2 record for cond_unit.
// Also holds the NZCV merge helper used for both the flag register and the bypass path.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit positions: [1] covers N,Z and [0] covers C,V
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    typedef struct packed {
        logic       valid;
        logic       cond_ex;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic [3:0] alu_flags;
        logic [1:0] flag_w;
    } stage2_t;

    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] alu,
                                               input logic [1:0] fw);
        logic [3:0] res;
        res = cur;
        if (fw[FLAGW_NZ]) begin
            res[FLAG_N] = alu[FLAG_N];
            res[FLAG_Z] = alu[FLAG_Z];
        end
        if (fw[FLAGW_CV]) begin
            res[FLAG_C] = alu[FLAG_C];
            res[FLAG_V] = alu[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Decode-to-condition-unit bus: instruction handshake in, gated enables and flag register out.
// master = decode side, slave = cond_unit.
interface cond_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [3:0] ALUFlags;
    logic       out_valid;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags,
        input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags,
        output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition decode: cond field against {N,Z,C,V} gives cond_ex.
// The NV encoding (1111) never executes.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Two-stage ARM condition unit: evaluate on transfer, gate enables, commit NZCV after stage 2.
// Build option COND_UNIT_FLAG_FWD_EN bypasses pending flag writes instead of stalling.
module cond_unit
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);

    stage2_t    s2, s2_next;
    logic [3:0] flags_q, flags_next, ef;
    logic       cond_ex, ready, xfer;

    // Flag value the register takes at the coming edge; also the bypass source
    assign flags_next = s2.valid ? merge_flags(flags_q, s2.alu_flags, s2.flag_w) : flags_q;

`ifdef COND_UNIT_FLAG_FWD_EN
    assign ef    = flags_next;
    assign ready = !reset;
`else
    logic hazard;

    // AL never reads flags, so it may follow a flag writer without a bubble
    assign hazard = s2.valid && (s2.flag_w != 2'b00) && bus.in_valid &&
                    (bus.Cond != COND_AL);
    assign ef     = flags_q;
    assign ready  = !reset && !hazard;
`endif

    cond_eval u_eval (
        .cond    (bus.Cond),
        .flags   (ef),
        .cond_ex (cond_ex)
    );

    assign xfer = bus.in_valid && ready;

    always_comb begin
        s2_next = '0;
        if (xfer) begin
            s2_next.valid     = 1'b1;
            s2_next.cond_ex   = cond_ex;
            s2_next.pc_src    = bus.PCS  && cond_ex;
            s2_next.reg_write = bus.RegW && cond_ex;
            s2_next.mem_write = bus.MemW && cond_ex;
            s2_next.alu_flags = bus.ALUFlags;
            s2_next.flag_w    = bus.FlagW & {2{cond_ex}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2      <= '0;
            flags_q <= '0;
        end else begin
            s2      <= s2_next;
            flags_q <= flags_next;
        end
    end

    // Outputs forced quiet while reset is held, including the cycle it first rises
    assign bus.in_ready  = ready;
    assign bus.out_valid = s2.valid     && !reset;
    assign bus.PCSrc     = s2.pc_src    && !reset;
    assign bus.RegWrite  = s2.reg_write && !reset;
    assign bus.MemWrite  = s2.mem_write && !reset;
    assign bus.CondEx    = s2.cond_ex   && !reset;
    assign bus.Flags     = reset ? 4'b0000 : flags_q;

endmodule
